// File: rtl/imem_loader_pkg.sv
// Shared state encoding and stream header constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int LEN_W  = 16;
  localparam int CSUM_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

endpackage

// File: rtl/word_packer.sv
// Packs incoming bytes big-endian into 32-bit words and emits one write strobe per word.
module word_packer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data
);

  logic [23:0] shift;
  logic [1:0]  lane;
  logic [31:0] word_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift    <= '0;
      lane     <= '0;
      word_idx <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_en <= 1'b0;
      if (clear) begin
        lane     <= '0;
        word_idx <= '0;
      end else if (byte_en) begin
        lane <= lane + 2'd1;
        if (lane == 2'd3) begin
          // Address and data stay put after the strobe until the next word lands.
          wr_en    <= 1'b1;
          wr_data  <= {shift, byte_in};
          wr_addr  <= BASE_ADDR + {word_idx[29:0], 2'b00};
          word_idx <= word_idx + 32'd1;
        end else begin
          shift <= {shift[15:0], byte_in};
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream boot loader: parses length header, writes words to instruction memory, verifies XOR checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        im_wr_en,
  output logic [31:0] im_wr_addr,
  output logic [31:0] im_wr_data,
  output logic        pc_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  state_t              state, next_state;
  logic [7:0]          len_hi;
  logic [CSUM_W-1:0]   csum;
  logic [LEN_W+1:0]    byte_cnt;
  logic                clear;
  logic                xfer;
  logic [LEN_W-1:0]    len_word;
  logic                too_long;

  assign byte_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                      (state == S_DATA)   || (state == S_CHECK);
  assign busy       = byte_ready;
  assign done       = (state == S_DONE);
  assign error      = (state == S_ERROR);
  assign pc_hold    = (state != S_DONE);

  assign xfer     = byte_valid && byte_ready;
  assign len_word = {len_hi, byte_in};
  assign too_long = 32'(len_word) > (32'd1 << ADDR_WIDTH);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    clear      = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          next_state = S_LEN_HI;
          clear      = 1'b1;
        end
      end
      S_LEN_HI: if (xfer) next_state = S_LEN_LO;
      S_LEN_LO: begin
        if (xfer) begin
          if (too_long)              next_state = S_ERROR;
          else if (len_word == '0)   next_state = S_CHECK;
          else                       next_state = S_DATA;
        end
      end
      S_DATA:  if (xfer && byte_cnt == 18'd1) next_state = S_CHECK;
      S_CHECK: if (xfer) next_state = (byte_in == csum) ? S_DONE : S_ERROR;
      default: next_state = S_IDLE;
    endcase
  end

  // Header/checksum datapath; byte_cnt holds the number of data bytes still owed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_hi   <= '0;
      csum     <= '0;
      byte_cnt <= '0;
    end else if (clear) begin
      csum     <= '0;
      byte_cnt <= '0;
    end else if (xfer) begin
      case (state)
        S_LEN_HI: begin
          len_hi <= byte_in;
          csum   <= csum ^ byte_in;
        end
        S_LEN_LO: begin
          byte_cnt <= {len_word, 2'b00};
          csum     <= csum ^ byte_in;
        end
        S_DATA: begin
          byte_cnt <= byte_cnt - 18'd1;
          csum     <= csum ^ byte_in;
        end
        default: ;
      endcase
    end
  end

  word_packer #(.BASE_ADDR(BASE_ADDR)) u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .byte_en (xfer && (state == S_DATA)),
    .byte_in (byte_in),
    .wr_en   (im_wr_en),
    .wr_addr (im_wr_addr),
    .wr_data (im_wr_data)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: header parsing, packing, checksum, overflow, reset and start handling.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n, start, byte_valid;
  logic [7:0]  byte_in;
  logic        byte_ready, im_wr_en, pc_hold, busy, done, error;
  logic [31:0] im_wr_addr, im_wr_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0]  stream_q [$];
  logic [31:0] wa_q [$];
  logic [31:0] wd_q [$];
  int          wc_q [$];

  imem_loader #(.ADDR_WIDTH(8), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .im_wr_en(im_wr_en),
    .im_wr_addr(im_wr_addr), .im_wr_data(im_wr_data), .pc_hold(pc_hold),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (im_wr_en) begin
      wa_q.push_back(im_wr_addr);
      wd_q.push_back(im_wr_data);
      wc_q.push_back(cyc);
    end
  end

  task automatic clr_writes();
    wa_q.delete(); wd_q.delete(); wc_q.delete();
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Streams stream_q back-to-back; start is raised alongside byte index start_at.
  task automatic send_stream(input int start_at);
    for (int i = 0; i < stream_q.size(); i++) begin
      byte_in    = stream_q[i];
      byte_valid = 1'b1;
      start      = (i == start_at);
      @(negedge clk);
      checks++;
      if (byte_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready byte %0d: byte_ready=%b expected 1", i, byte_ready);
      end
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic check_status(input string name, input logic e_done, input logic e_err,
                              input logic e_hold, input logic e_busy);
    @(negedge clk);
    checks++;
    if ({done, error, pc_hold, busy} !== {e_done, e_err, e_hold, e_busy}) begin
      errors++;
      $display("FAIL %s: done/error/pc_hold/busy=%b%b%b%b expected %b%b%b%b",
               name, done, error, pc_hold, busy, e_done, e_err, e_hold, e_busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({byte_ready, im_wr_en, pc_hold, busy, done, error} !== 6'b001000) begin
      errors++;
      $display("FAIL reset_ctrl: rdy/wen/hold/busy/done/err=%b%b%b%b%b%b expected 001000",
               byte_ready, im_wr_en, pc_hold, busy, done, error);
    end
    checks++;
    if (im_wr_addr !== 32'h0 || im_wr_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: addr=%h data=%h expected 0/0", im_wr_addr, im_wr_data);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_word();
    clr_writes();
    do_start();
    check_status("single_busy", 1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    stream_q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    send_stream(-1);
    check_status("single_done", 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (wa_q.size() != 1 || wa_q[0] !== 32'h0 || wd_q[0] !== 32'h12345678) begin
      errors++;
      $display("FAIL single_write: count=%0d addr=%h data=%h expected 1/00000000/12345678",
               wa_q.size(), (wa_q.size() > 0) ? wa_q[0] : 32'hx, (wd_q.size() > 0) ? wd_q[0] : 32'hx);
    end
  endtask

  task automatic test_back_to_back();
    clr_writes();
    do_start();
    stream_q = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h8A};
    send_stream(-1);
    check_status("b2b_done", 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (wa_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: writes=%0d expected 2", wa_q.size());
    end else begin
      checks++;
      if (wa_q[0] !== 32'h0 || wa_q[1] !== 32'h4 || wd_q[0] !== 32'h11223344 || wd_q[1] !== 32'h55667788) begin
        errors++;
        $display("FAIL b2b_words: %h=%h %h=%h expected 0=11223344 4=55667788",
                 wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
      end
      checks++;
      if (wc_q[1] - wc_q[0] != 4) begin
        errors++;
        $display("FAIL b2b_spacing: write gap=%0d cycles expected 4", wc_q[1] - wc_q[0]);
      end
    end
  endtask

  task automatic test_bad_checksum();
    clr_writes();
    do_start();
    stream_q = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    send_stream(-1);
    check_status("badsum_error", 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (wa_q.size() != 1 || wd_q[0] !== 32'hAABBCCDD) begin
      errors++;
      $display("FAIL badsum_write: count=%0d data=%h expected 1/AABBCCDD",
               wa_q.size(), (wd_q.size() > 0) ? wd_q[0] : 32'hx);
    end
  endtask

  task automatic test_overflow();
    clr_writes();
    do_start();
    stream_q = '{8'h01, 8'h01};
    send_stream(-1);
    check_status("ovf_error", 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL ovf_ready: byte_ready=%b expected 0", byte_ready);
    end
    // Boundary: exactly 2^ADDR_WIDTH words is accepted, so the header moves on to DATA.
    do_start();
    stream_q = '{8'h01, 8'h00};
    send_stream(-1);
    check_status("len_max_ok", 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) @(posedge clk); #1;
    checks++;
    if (wa_q.size() != 0) begin
      errors++;
      $display("FAIL ovf_writes: writes=%0d expected 0", wa_q.size());
    end
    rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_mid_reset();
    clr_writes();
    do_start();
    stream_q = '{8'h00, 8'h01, 8'hAA, 8'hBB};
    send_stream(-1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_status("midrst_idle", 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(posedge clk); #1;
    checks++;
    if (wa_q.size() != 0) begin
      errors++;
      $display("FAIL midrst_nowrite: writes=%0d expected 0", wa_q.size());
    end
    do_start();
    stream_q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    send_stream(-1);
    check_status("midrst_reload", 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (wa_q.size() != 1 || wa_q[0] !== 32'h0 || wd_q[0] !== 32'h12345678) begin
      errors++;
      $display("FAIL midrst_write: count=%0d addr=%h data=%h expected 1/00000000/12345678",
               wa_q.size(), (wa_q.size() > 0) ? wa_q[0] : 32'hx, (wd_q.size() > 0) ? wd_q[0] : 32'hx);
    end
  endtask

  task automatic test_zero_len_and_start_ignored();
    clr_writes();
    do_start();
    stream_q = '{8'h00, 8'h00, 8'h00};
    send_stream(-1);
    check_status("zero_done", 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (wa_q.size() != 0) begin
      errors++;
      $display("FAIL zero_writes: writes=%0d expected 0", wa_q.size());
    end
    clr_writes();
    do_start();
    stream_q = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23};
    send_stream(3);
    check_status("start_ign_done", 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (wa_q.size() != 1 || wa_q[0] !== 32'h0 || wd_q[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL start_ign_write: count=%0d addr=%h data=%h expected 1/00000000/DEADBEEF",
               wa_q.size(), (wa_q.size() > 0) ? wa_q[0] : 32'hx, (wd_q.size() > 0) ? wd_q[0] : 32'hx);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_bad_checksum();
    test_overflow();
    test_mid_reset();
    test_zero_len_and_start_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
